// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO write-side arbiter.
package fifo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 4;

  // Beat counter must hold 0..MAX_BURST.
  function automatic int beat_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first set req bit after index last, wrapping.
module fifo_rr_pick
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      // last < NUM_REQ and k <= NUM_REQ, so one conditional subtract wraps.
      sum = {1'b0, last} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        winner[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for FIFO write requesters.
// Optional per-requester word counters: define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                         wclk,
  input  logic                         wrst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic                         wfull,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           ack,
  output logic [DATA_SIZE-1:0]         wdata,
  output logic                         wclk_en,
  output logic                         busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]        stat_cnt
`endif
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = beat_width(MAX_BURST);

  arb_state_t          state, next_state;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [IDX_W-1:0]    g_idx;
  logic [IDX_W-1:0]    last;
  logic [BEAT_W-1:0]   beat;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                burst_end;

  fifo_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .last   (last),
    .winner (pick_onehot),
    .idx    (pick_idx)
  );

  // Handshake: req[g] is valid, !wfull is ready; a word moves (ack/wclk_en)
  // only in a cycle where both are high. Dropping req[g] ends the burst.
  always_comb begin
    next_state = state;
    wclk_en    = 1'b0;
    ack        = '0;
    wdata      = '0;
    burst_end  = 1'b0;
    case (state)
      IDLE: if (|req) next_state = XFER;
      XFER: begin
        wclk_en = req[g_idx] && !wfull;
        ack     = wclk_en ? gnt_q : '0;
        wdata   = req_data[g_idx*DATA_SIZE +: DATA_SIZE];
        if (!req[g_idx])
          burst_end = 1'b1;
        else if (wclk_en && (req_last[g_idx] || beat == BEAT_W'(MAX_BURST-1)))
          burst_end = 1'b1;
        if (burst_end) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state <= IDLE;
      gnt_q <= '0;
      g_idx <= '0;
      beat  <= '0;
      last  <= IDX_W'(NUM_REQ-1);
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (|req) begin
          gnt_q <= pick_onehot;
          g_idx <= pick_idx;
          beat  <= '0;
        end
        XFER: if (burst_end) begin
          gnt_q <= '0;
          last  <= g_idx;
          beat  <= '0;
        end else if (wclk_en) begin
          beat <= beat + BEAT_W'(1);
        end
        default: gnt_q <= '0;
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state != IDLE);

`ifdef FIFO_WR_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [15:0] cnt;
    always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) cnt <= '0;
      else if (ack[i] && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
    assign stat_cnt[i*16 +: 16] = cnt;
  end
`endif

endmodule
